// File: rtl/ble_config_loader.sv
// ble_config_loader: serialises a byte-wide configuration image into the daisy-chained BLE shift registers
module ble_config_loader #(
    parameter int NUM_BLE      = 8,
    parameter int BITS_PER_BLE = 19,
    parameter int CLK_DIV      = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic [7:0] i_in_data,
    input  logic       i_in_valid,
    output logic       o_in_ready,
    output logic       o_prog_in,
    output logic       o_prog_clk,
    output logic       o_prog_en,
    output logic       o_busy,
    output logic       o_done
);
    localparam int CHAIN_LEN = NUM_BLE * BITS_PER_BLE;
    localparam int NBYTES    = CHAIN_LEN / 8;
    localparam int DW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW        = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BYTE_LAST = BW'(NBYTES - 1);

    generate
        if (NUM_BLE % 8 != 0) begin : g_bad_num_ble
            $error("ble_config_loader: NUM_BLE must be a multiple of 8");
        end
        if (CLK_DIV < 1) begin : g_bad_clk_div
            $error("ble_config_loader: CLK_DIV must be at least 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SHIFT_LO,
        S_SHIFT_HI,
        S_TAIL
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [DW-1:0]   r_div_cnt;
    logic [2:0]      r_bit_cnt;
    logic [BW-1:0]   r_byte_cnt;
    logic [7:0]      r_shift;
    logic            r_in_ready;
    logic            r_prog_clk;
    logic            r_prog_en;
    logic            r_busy;
    logic            r_done;
    logic            w_phase_end;
    logic            w_accept;
    logic            w_hi_exit;
    logic            w_timed;
    logic            w_in_ready_nxt;
    logic            w_prog_clk_nxt;
    logic            w_prog_en_nxt;
    logic            w_busy_nxt;
    logic            w_done_nxt;

    assign w_phase_end = (r_div_cnt == DIV_LAST);
    assign w_accept    = (r_state == S_FETCH) & r_in_ready & i_in_valid;
    assign w_hi_exit   = (r_state == S_SHIFT_HI) & w_phase_end;
    assign w_timed     = (r_state == S_SHIFT_LO) | (r_state == S_SHIFT_HI) | (r_state == S_TAIL);

    // State register; reset drops straight back to IDLE even mid-load
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state: each timed phase lasts CLK_DIV cycles, FETCH waits for a byte
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:     w_state_nxt = i_start ? S_FETCH : S_IDLE;
            S_FETCH:    w_state_nxt = w_accept ? S_SHIFT_LO : S_FETCH;
            S_SHIFT_LO: w_state_nxt = w_phase_end ? S_SHIFT_HI : S_SHIFT_LO;
            S_SHIFT_HI: w_state_nxt = !w_phase_end ? S_SHIFT_HI :
                                      (r_bit_cnt != 3'd0) ? S_SHIFT_LO :
                                      (r_byte_cnt != '0) ? S_FETCH : S_TAIL;
            S_TAIL:     w_state_nxt = w_phase_end ? S_IDLE : S_TAIL;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode from the next state so the registered outputs line up with the state register
    always_comb begin
        w_in_ready_nxt = (w_state_nxt == S_FETCH);
        w_prog_clk_nxt = (w_state_nxt == S_SHIFT_HI);
        w_busy_nxt     = (w_state_nxt != S_IDLE);
        w_done_nxt     = (r_state == S_TAIL) & w_phase_end;
        w_prog_en_nxt  = w_accept | (r_prog_en & (w_state_nxt != S_IDLE));
    end

    // Output registers; prog_en stays high through stalls and falls only on TAIL exit or reset
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_in_ready <= 1'b0;
            r_prog_clk <= 1'b0;
            r_prog_en  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_in_ready <= w_in_ready_nxt;
            r_prog_clk <= w_prog_clk_nxt;
            r_prog_en  <= w_prog_en_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
        end
    end

    // Phase timer, bit/byte counters and the MSB-first data shifter
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_div_cnt  <= '0;
            r_bit_cnt  <= 3'd0;
            r_byte_cnt <= '0;
            r_shift    <= 8'd0;
        end else begin
            r_div_cnt  <= (w_timed && w_state_nxt == r_state) ? r_div_cnt + 1'b1 : '0;
            r_bit_cnt  <= w_accept ? 3'd7 : (w_hi_exit && r_bit_cnt != 3'd0) ? r_bit_cnt - 3'd1 : r_bit_cnt;
            r_byte_cnt <= (r_state == S_IDLE && i_start) ? BYTE_LAST :
                          (w_hi_exit && r_bit_cnt == 3'd0 && r_byte_cnt != '0) ? r_byte_cnt - 1'b1 : r_byte_cnt;
            r_shift    <= w_accept ? i_in_data : w_hi_exit ? {r_shift[6:0], 1'b0} : r_shift;
        end
    end

    assign o_in_ready = r_in_ready;
    assign o_prog_in  = r_shift[7];
    assign o_prog_clk = r_prog_clk;
    assign o_prog_en  = r_prog_en;
    assign o_busy     = r_busy;
    assign o_done     = r_done;

endmodule

// File: tb/tb_ble_config_loader.sv
// tb_ble_config_loader: scoreboard bench driving byte images into a model of the chained BLE shift/commit registers
`timescale 1ns/1ps
module tb_ble_config_loader;
    localparam int NUM_BLE  = 8;
    localparam int BPB      = 19;
    localparam int DIV      = 2;
    localparam int CL       = NUM_BLE * BPB;
    localparam int NB       = CL / 8;
    localparam int DONE_CYC = 1 + NB * (1 + 16 * DIV) + DIV;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       start_alt = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       in_ready, prog_in, prog_clk, prog_en, busy, done;

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;
    int c0 = 0;
    int alt_c0 = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ble_config_loader dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_start    (start),
        .i_in_data  (in_data),
        .i_in_valid (in_valid),
        .o_in_ready (in_ready),
        .o_prog_in  (prog_in),
        .o_prog_clk (prog_clk),
        .o_prog_en  (prog_en),
        .o_busy     (busy),
        .o_done     (done)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // BLE chain model: capture the setup value on each prog_clk rise, commit on the prog_en fall
    logic [CL-1:0]  chain = '0;
    logic [BPB-1:0] exp_q[$];
    logic p_clk = 1'b0, p_en = 1'b0, p_in = 1'b0;
    int rises = 0, dones = 0, commits = 0, done_at = 0, last_fall = 0, en_gap = 0, bad_en = 0, bad_stall = 0;
    always @(negedge clk) begin
        p_clk <= prog_clk;
        p_en  <= prog_en;
        p_in  <= prog_in;
        if (rst_n) begin
            if (prog_clk && !p_clk) begin
                chain <= {chain[CL-2:0], p_in};
                rises <= rises + 1;
                if (!prog_en) bad_en <= bad_en + 1;
            end
            if (!prog_clk && p_clk) last_fall <= cyc;
            if (in_ready && prog_clk) bad_stall <= bad_stall + 1;
            if (done) begin
                dones   <= dones + 1;
                done_at <= cyc - c0 + 1;
            end
            if (!prog_en && p_en) begin
                commits <= commits + 1;
                en_gap  <= cyc - last_fall;
                for (int k = 0; k < NUM_BLE; k++) begin
                    check($sformatf("sb_avail%0d", k), int'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) check($sformatf("ble%0d", k), int'(chain[k*BPB +: BPB]), int'(exp_q.pop_front()));
                end
            end
        end
    end

    // Two extra loaders with other divider settings, fed a constant 0x5A stream
    generate
        for (genvar g = 0; g < 2; g++) begin : g_alt
            localparam int D = (g == 0) ? 1 : 4;
            logic a_ready, a_in, a_clk, a_en, a_busy, a_done;
            logic pc = 1'b0, pe = 1'b0, pi = 1'b0;
            int a_rises = 0, a_ones = 0, last_rise = 0, pmin = 1000, pmax = 0, a_fall = 0, gap = 0, a_done_at = 0;
            ble_config_loader #(.CLK_DIV(D)) dut_alt (
                .i_clk      (clk),
                .i_rst_n    (rst_n),
                .i_start    (start_alt),
                .i_in_data  (8'h5A),
                .i_in_valid (1'b1),
                .o_in_ready (a_ready),
                .o_prog_in  (a_in),
                .o_prog_clk (a_clk),
                .o_prog_en  (a_en),
                .o_busy     (a_busy),
                .o_done     (a_done)
            );
            always @(negedge clk) begin
                pc <= a_clk;
                pe <= a_en;
                pi <= a_in;
                if (a_clk && !pc) begin
                    a_rises   <= a_rises + 1;
                    a_ones    <= a_ones + (pi ? 1 : 0);
                    last_rise <= cyc;
                    if (a_rises > 0) begin
                        pmin <= (cyc - last_rise < pmin) ? cyc - last_rise : pmin;
                        pmax <= (cyc - last_rise > pmax) ? cyc - last_rise : pmax;
                    end
                end
                if (!a_clk && pc) a_fall <= cyc;
                if (!a_en && pe) gap <= cyc - a_fall;
                if (a_done) a_done_at <= cyc - alt_c0 + 1;
            end
        end
    endgenerate

    logic [7:0] img_b [NB];

    task automatic load(input int stall_max, input bit restart);
        logic [CL-1:0] img = '0;
        int r0 = rises;
        int d0 = dones;
        int m0 = commits;
        int n;
        for (int i = 0; i < NB; i++) img = {img[CL-9:0], img_b[i]};
        for (int k = 0; k < NUM_BLE; k++) exp_q.push_back(img[k*BPB +: BPB]);
        in_data  = img_b[0];
        in_valid = (stall_max == 0);
        start    = 1'b1;
        @(posedge clk);
        #1 c0 = cyc;
        @(negedge clk);
        start = 1'b0;
        fork
            begin
                for (int i = 0; i < NB; i++) begin
                    in_data  = img_b[i];
                    in_valid = (stall_max == 0);
                    n = 0;
                    while (!in_ready && n < 200) begin
                        @(negedge clk);
                        n++;
                    end
                    if (n >= 200) check("ready_timeout", n, 0);
                    if (stall_max > 0) begin
                        repeat ($urandom_range(stall_max, 0)) @(negedge clk);
                        in_valid = 1'b1;
                    end
                    @(negedge clk);
                end
                in_valid = 1'b0;
            end
            if (restart) begin
                repeat (98) @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        join
        n = 0;
        while (commits == m0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("commit_seen", commits - m0, 1);
        check("rises", rises - r0, CL);
        check("dones", dones - d0, 1);
        check("en_gap", en_gap, DIV);
        if (stall_max == 0) check("done_cycle", done_at, DONE_CYC);
        check("busy_after", int'(busy), 0);
    endtask

    initial begin
        int n;
        int r0;
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hFF;
        repeat (3) @(negedge clk);
        check("rst_ready", int'(in_ready), 0);
        check("rst_prog_in", int'(prog_in), 0);
        check("rst_prog_clk", int'(prog_clk), 0);
        check("rst_prog_en", int'(prog_en), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_ready", int'(in_ready), 0);
        check("idle_busy", int'(busy), 0);
        in_valid = 1'b0;

        for (int i = 0; i < NB; i++) img_b[i] = (i == 0) ? 8'h80 : 8'h00;
        load(0, 1'b0);
        check("single_bit_ble7", int'(chain[CL-1]), 1);

        for (int i = 0; i < NB; i++) img_b[i] = 8'($urandom);
        load(10, 1'b0);

        for (int i = 0; i < NB; i++) img_b[i] = 8'($urandom);
        load(0, 1'b1);

        in_data  = 8'hC3;
        in_valid = 1'b1;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        r0 = rises;
        n  = 0;
        while (rises - r0 < 40 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("mid_rises", rises - r0, 40);
        rst_n = 1'b0;
        #1;
        check("mid_rst_en", int'(prog_en), 0);
        check("mid_rst_clk", int'(prog_clk), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_ready", int'(in_ready), 0);
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_busy", int'(busy), 0);
        check("post_rst_ready", int'(in_ready), 0);
        for (int i = 0; i < NB; i++) img_b[i] = 8'($urandom);
        load(3, 1'b0);

        check("bad_en", bad_en, 0);
        check("bad_stall", bad_stall, 0);
        check("sb_left", exp_q.size(), 0);

        start_alt = 1'b1;
        @(posedge clk);
        #1 alt_c0 = cyc;
        @(negedge clk);
        start_alt = 1'b0;
        n = 0;
        while ((g_alt[0].a_done_at == 0 || g_alt[1].a_done_at == 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check("div1_done", g_alt[0].a_done_at, 1 + NB * 17 + 1);
        check("div4_done", g_alt[1].a_done_at, 1 + NB * 65 + 4);
        check("div1_pmin", g_alt[0].pmin, 2);
        check("div4_pmin", g_alt[1].pmin, 8);
        check("div1_pmax", g_alt[0].pmax, 3);
        check("div4_pmax", g_alt[1].pmax, 9);
        check("div1_gap", g_alt[0].gap, 1);
        check("div4_gap", g_alt[1].gap, 4);
        check("div1_rises", g_alt[0].a_rises, CL);
        check("div4_rises", g_alt[1].a_rises, CL);
        check("div1_ones", g_alt[0].a_ones, NB * 4);
        check("div4_ones", g_alt[1].a_ones, NB * 4);
        check("div1_idle", int'(g_alt[0].a_busy | g_alt[0].a_ready), 0);
        check("div4_idle", int'(g_alt[1].a_busy | g_alt[1].a_ready), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/ble_config_loader.md
# ble_config_loader

Configuration front-end for the BLE programming chain. Accepts a byte stream of the logic array's configuration image over a valid/ready interface and serialises it into the daisy-chained BLE shift registers. It drives `prog_in`, `prog_clk` and `prog_en` into the first BLE of the chain. It ends each load with the falling edge of `prog_en`; on that edge every BLE transfers its shifted image into its active control register.

## Interface
- `NUM_BLE`, default 8: BLEs in the chain. Must be a multiple of 8; any other value is an elaboration error.
- `BITS_PER_BLE`, default 19: control bits per BLE (16 LUT, FF-enable mux, LUT-input mux, output mux).
- `CLK_DIV`, default 2: `clk` cycles per `prog_clk` half-period. Must be ≥1.
- Derived: `CHAIN_LEN = NUM_BLE*BITS_PER_BLE` (152 by default) and `NBYTES = CHAIN_LEN/8` (19 by default).

Ports:
- `clk`  in  1  system clock. This is the block's only clock; every output is registered on it.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  single-cycle request to begin a load. Sampled only in IDLE.
- `in_data`  in  8  configuration byte.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  the loader accepts a byte this cycle.
- `prog_in`  out  1  serial configuration bit into BLE 0.
- `prog_clk`  out  1  shift clock for the chain.
- `prog_en`  out  1  shift enable. Its falling edge commits the image.
- `busy`  out  1  a load is in progress.
- `done`  out  1  one-cycle pulse when a load completes.

## Operation
- Image indexing: bit `j` of BLE `k` is image index `k*BITS_PER_BLE + j`. BLE 0 is nearest the loader.
- Stream order: bytes are sent MSB-first. The first streamed bit is image index `CHAIN_LEN-1`, so it travels to BLE `NUM_BLE-1` bit 18. The last streamed bit is index 0.
- States: IDLE, FETCH, SHIFT_LO, SHIFT_HI, TAIL.
  - IDLE → FETCH when `start`=1. `busy` rises on the same edge.
  - FETCH: `in_ready`=1 and `prog_clk`=0. On `in_valid & in_ready` the byte is captured into the shift register, the bit counter is set to 7, and the state moves to SHIFT_LO. The first accepted byte of a load also sets `prog_en`=1.
  - SHIFT_LO (`CLK_DIV` cycles): `prog_in` = current MSB and `prog_clk`=0. → SHIFT_HI.
  - SHIFT_HI (`CLK_DIV` cycles): `prog_clk`=1 and `prog_in` held stable. On exit the data shifts left and the counters decrement. The next state is:
    - SHIFT_LO if bits remain in the byte;
    - FETCH if the byte is done but bytes remain;
    - TAIL after the last bit of byte `NBYTES-1`.
  - TAIL (`CLK_DIV` cycles): `prog_clk`=0 and `prog_en`=1. On exit `prog_en`←0, `done`←1 for one cycle, `busy`←0, and the state returns to IDLE.
- Exactly `CHAIN_LEN` rising edges of `prog_clk` occur per load. `prog_clk` never rises while `prog_en`=0.
- `prog_en` only falls while `prog_clk`=0 and at least `CLK_DIV` cycles after the last `prog_clk` fall.
- `start` is ignored while `busy`=1.
- Upstream stalls: FETCH waits indefinitely. `prog_clk` stays low and `prog_en` stays high, so partial shifting is preserved.
- Reset mid-load: all outputs clear asynchronously. The resulting `prog_en` fall latches a partial image into the BLEs. The system must issue a new full load afterwards; the loader does not track this.

## Timing
- Reset values: `in_ready`=0, `prog_in`=0, `prog_clk`=0, `prog_en`=0, `busy`=0, `done`=0. State is IDLE and all counters are 0.
- Each bit occupies 2*`CLK_DIV` cycles. `prog_in` changes only on the cycle `prog_clk` goes low or in FETCH, giving `CLK_DIV` cycles of setup before the rising edge.
- Each byte takes 1 FETCH cycle (with `in_valid` already high) plus 16*`CLK_DIV` cycles.
- With `in_valid` held at 1, `done` asserts `1 + NBYTES*(1+16*CLK_DIV) + CLK_DIV` cycles after the edge that samples `start`. For the defaults this is 630 cycles.
- `in_ready` is high only in FETCH, so at most one byte is accepted per FETCH visit.

## Test plan
- Reset with `start` and `in_valid` asserted → all outputs 0; `in_ready` stays 0 until after `start`.
- Default parameters, 19 bytes 0x80,0x00,… with `in_valid` always high, 19-bit model BLEs chained → `done` at cycle 630; 152 `prog_clk` rises; only BLE 7 control[18]=1 after the `prog_en` fall.
- Random 19-byte image with `in_valid` randomly dropped for 0–10 cycles → each BLE's control equals its image slice; `prog_clk` stays low during every stall.
- `start` pulsed again at cycle 100 of a load → ignored; exactly one `done` and 152 `prog_clk` rises.
- `CLK_DIV`=1 and `CLK_DIV`=4 → bit period of 2 and 8 cycles respectively; `prog_en` falls `CLK_DIV` cycles after the last `prog_clk` fall.
- `rst_n` asserted after 40 `prog_clk` rises → `prog_en` drops immediately; the loader returns to IDLE; a subsequent full load produces the correct image.
